ma_stage: RTL and testbench
===========================

# ma_stage

Memory-access stage of the five-stage pipeline, between the EX/MA latch and `MA_RW_Latch`. It performs loads and stores through a ready/valid data-memory port and stalls the upstream pipeline while a memory access is outstanding. While stalled it sends bubbles downstream. Its outputs drive the `MA_RW_Latch` inputs directly.

## Interface
- `LD_BIT`, 5: index of the isLd bit in the 22-bit control bus.
- `ST_BIT`, 6: index of the isSt bit in the 22-bit control bus.
- `TIMEOUT`, 16: maximum number of cycles spent in REQ waiting for `mem_ready`. Legal range 2..255.
- `NOP_IR`, 32'h68000000: instruction word emitted in bubbles.

Ports:
- `clk` in 1: clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `input_MA_PC` in 32: PC from the EX/MA latch.
- `input_MA_ALU_Result` in 32: ALU result. For ld/st this is the byte address.
- `input_MA_op2` in 32: store data.
- `input_MA_IR` in 32: instruction word.
- `input_MA_controlBus` in 22: control bus.
- `output_MA_PC`, `output_MA_ALU_Result`, `output_MA_IR` out 32: to `MA_RW_Latch`.
- `output_MA_controlBus` out 22: to `MA_RW_Latch`.
- `MA_Ld_Result` out 32: load data.
- `ma_stall` out 1: high means upstream latches and PC must hold.
- `mem_req` out 1: memory request valid.
- `mem_we` out 1: 1 = store, 0 = load.
- `mem_addr` out 32: byte address, always word-aligned.
- `mem_wdata` out 32: store data.
- `mem_rdata` in 32: load data, valid when `mem_ready` is high.
- `mem_ready` in 1: completes the current request.
- `mem_err` out 1: sticky error flag. Cleared only by reset.

## Operation
States are IDLE, REQ and DONE. Define `memop = ctrl[LD_BIT] | ctrl[ST_BIT]`.

- **IDLE, `memop` = 0:** pure pass-through.
  - Outputs equal the inputs combinationally.
  - `MA_Ld_Result` = 0, `ma_stall` = 0, `mem_req` = 0.
- **IDLE, `memop` = 1:**
  - Combinationally: `ma_stall` = 1, and a bubble is output (controlBus = 0, IR = `NOP_IR`, PC and ALU_Result passed through, `MA_Ld_Result` = 0).
  - On the clock edge: capture PC, IR, ALU result, op2 and ctrl into hold registers.
  - If `ALU_Result[1:0]` ≠ 0 (misaligned): set `mem_err`, load data = 0, go to DONE. No request is issued.
  - Otherwise go to REQ.
- **REQ:**
  - Outputs: `mem_req` = 1, `mem_addr` = held address, `mem_we` = held isSt, `mem_wdata` = held op2.
  - `ma_stall` = 1, and a bubble is output with the held PC.
  - A cycle counter starts at 0 on entry.
  - On an edge with `mem_ready` = 1: capture `mem_rdata` (load) or 0 (store), go to DONE.
  - Else, if counter = `TIMEOUT`-1: set `mem_err`, data = 0, go to DONE.
  - Else, increment the counter.
- **DONE:**
  - Outputs are the held PC, IR, ALU result and ctrl; `MA_Ld_Result` = captured data.
  - `ma_stall` = 0, `mem_req` = 0.
  - Next state is always IDLE. The instruction still present on the inputs during DONE is not re-issued, because upstream advances at the end of DONE.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are held stable for the whole REQ dwell.
- If isLd and isSt are both set, the operation is treated as a store.

## Timing
- **Reset (async):**
  - State = IDLE; counter, hold registers and `mem_err` = 0.
  - `mem_req` = 0 and `mem_we` = 0 immediately.
  - Outputs follow the IDLE rules on the current inputs.
  - A reset during REQ abandons the request; no completion is produced.
- **Non-memory instruction:** 0 added latency.
- **Memory instruction:** IDLE 1 cycle + REQ n cycles (n ≥ 1; n = 1 when `mem_ready` is high in the first REQ cycle) + DONE 1 cycle. Minimum 3 cycles.
  - `ma_stall` is high for n+1 cycles.
  - Exactly one real copy of the instruction reaches `MA_RW_Latch`, during DONE. The output is a bubble for n+1 cycles before it.
- **Back-to-back memory ops:** DONE → IDLE → REQ. The bubble pattern repeats; no cycle is lost beyond the above.
- **Timeout:** REQ lasts exactly `TIMEOUT` cycles, then DONE. `mem_err` rises at the edge entering DONE.
- **Misaligned access:** IDLE → DONE, 2 cycles, `mem_req` never asserted.
- `mem_ready` is ignored outside REQ.

## Test plan
- **ALU op:** IR = 0x00000000, ALU_Result = 0x1234, ctrl with no ld/st bit → outputs identical same cycle, `ma_stall` = 0, `mem_req` never 1.
- **Load, immediate ready:** address 0x100, `mem_ready` high in the first REQ cycle, `mem_rdata` = 0xDEADBEEF → `ma_stall` high for 2 cycles, bubbles for 2 cycles, then DONE with `MA_Ld_Result` = 0xDEADBEEF and the original IR/ctrl.
- **Store with 3-cycle wait:** address 0x200, op2 = 0xCAFEF00D → `mem_req`/`mem_we` = 1 with stable addr/data for 3 cycles, `MA_Ld_Result` = 0 in DONE, `ma_stall` high for 4 cycles.
- **Timeout:** `TIMEOUT` = 4, `mem_ready` held low → REQ lasts 4 cycles, `mem_err` = 1, `MA_Ld_Result` = 0; `mem_err` stays 1 through later operations.
- **Misaligned:** load at address 0x102 → no `mem_req`, `mem_err` = 1, DONE on the second cycle.
- **Reset in REQ:** assert `rst_n` = 0 on the second REQ cycle → `mem_req` drops without waiting for a clock edge, state = IDLE, `mem_err` = 0, no DONE output appears.

Source files
------------

// File: rtl/ma_stage.sv
// ma_stage: memory-access pipeline stage. Passes non-memory instructions
// straight through. Memory instructions are held in local registers while a
// ready/valid data-memory request runs; the stage stalls upstream and emits
// bubbles until the access completes, then emits the real instruction once.
module ma_stage #(
   parameter int          LD_BIT  = 5,
   parameter int          ST_BIT  = 6,
   parameter int          TIMEOUT = 16,
   parameter logic [31:0] NOP_IR  = 32'h6800_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] input_MA_PC,
   input  logic [31:0] input_MA_ALU_Result,
   input  logic [31:0] input_MA_op2,
   input  logic [31:0] input_MA_IR,
   input  logic [21:0] input_MA_controlBus,
   output logic [31:0] output_MA_PC,
   output logic [31:0] output_MA_ALU_Result,
   output logic [31:0] output_MA_IR,
   output logic [21:0] output_MA_controlBus,
   output logic [31:0] MA_Ld_Result,
   output logic        ma_stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        mem_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] pc_q, pc_d, ir_q, ir_d, alu_q, alu_d, op2_q, op2_d, data_q, data_d;
   logic [21:0] ctrl_q, ctrl_d;
   logic        err_q, err_d;
   logic        memop;

   assign memop = input_MA_controlBus[LD_BIT] | input_MA_controlBus[ST_BIT];

   // Next-state: capture the instruction in IDLE, run/timeout the request in REQ
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      alu_d   = alu_q;
      op2_d   = op2_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = 8'd0;
            if (memop) begin
               pc_d   = input_MA_PC;
               ir_d   = input_MA_IR;
               alu_d  = input_MA_ALU_Result;
               op2_d  = input_MA_op2;
               ctrl_d = input_MA_controlBus;
               if (input_MA_ALU_Result[1:0] != 2'b00) begin
                  // misaligned: fail locally, never touch memory
                  err_d   = 1'b1;
                  data_d  = 32'd0;
                  state_d = S_DONE;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (mem_ready) begin
               // ld+st together behaves as a store, so store wins here
               data_d  = ctrl_q[ST_BIT] ? 32'd0 : mem_rdata;
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               data_d  = 32'd0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and hold registers; reset abandons any outstanding request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         pc_q    <= 32'd0;
         ir_q    <= 32'd0;
         alu_q   <= 32'd0;
         op2_q   <= 32'd0;
         ctrl_q  <= 22'd0;
         data_q  <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         alu_q   <= alu_d;
         op2_q   <= op2_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   // Downstream outputs: pass-through, bubble while stalled, held copy in DONE
   always_comb begin
      output_MA_PC         = input_MA_PC;
      output_MA_ALU_Result = input_MA_ALU_Result;
      output_MA_IR         = input_MA_IR;
      output_MA_controlBus = input_MA_controlBus;
      MA_Ld_Result         = 32'd0;
      ma_stall             = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (memop) begin
               output_MA_IR         = NOP_IR;
               output_MA_controlBus = 22'd0;
               ma_stall             = 1'b1;
            end
         end
         S_REQ: begin
            output_MA_PC         = pc_q;
            output_MA_ALU_Result = alu_q;
            output_MA_IR         = NOP_IR;
            output_MA_controlBus = 22'd0;
            ma_stall             = 1'b1;
         end
         S_DONE: begin
            output_MA_PC         = pc_q;
            output_MA_ALU_Result = alu_q;
            output_MA_IR         = ir_q;
            output_MA_controlBus = ctrl_q;
            MA_Ld_Result         = data_q;
         end
         default: ;
      endcase
   end

   // Memory port: driven from hold registers so it stays stable through REQ
   assign mem_req   = (state_q == S_REQ);
   assign mem_we    = (state_q == S_REQ) & ctrl_q[ST_BIT];
   assign mem_addr  = {alu_q[31:2], 2'b00};
   assign mem_wdata = op2_q;
   assign mem_err   = err_q;

endmodule

// File: tb/tb_ma_stage.sv
// Testbench for ma_stage: directed scenarios followed by random instructions,
// checked cycle by cycle against a timeline model of the stage.
module tb_ma_stage;
   localparam int          TO  = 4;
   localparam logic [31:0] NOP = 32'h6800_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] in_pc = '0, in_alu = '0, in_op2 = '0, in_ir = '0;
   logic [21:0] in_ctrl = '0;
   logic [31:0] o_pc, o_alu, o_ir, ld_res, m_addr, m_wdata;
   logic [21:0] o_ctrl;
   logic        stall, m_req, m_we, m_err;
   logic [31:0] m_rdata = '0;
   logic        m_ready = 1'b0;

   int tests = 0;
   int fails = 0;
   logic err_exp = 1'b0;
   logic [31:0] mem_model [logic [31:0]];

   ma_stage #(.LD_BIT(5), .ST_BIT(6), .TIMEOUT(TO), .NOP_IR(NOP)) dut (
      .clk(clk), .rst_n(rst_n),
      .input_MA_PC(in_pc), .input_MA_ALU_Result(in_alu), .input_MA_op2(in_op2),
      .input_MA_IR(in_ir), .input_MA_controlBus(in_ctrl),
      .output_MA_PC(o_pc), .output_MA_ALU_Result(o_alu), .output_MA_IR(o_ir),
      .output_MA_controlBus(o_ctrl), .MA_Ld_Result(ld_res), .ma_stall(stall),
      .mem_req(m_req), .mem_we(m_we), .mem_addr(m_addr), .mem_wdata(m_wdata),
      .mem_rdata(m_rdata), .mem_ready(m_ready), .mem_err(m_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // One instruction through the stage. wait_n = REQ cycle in which memory
   // answers; wait_n > TO means memory never answers.
   task automatic do_op(input logic [31:0] pc, input logic [31:0] ir, input logic [31:0] alu,
                        input logic [31:0] op2, input logic [21:0] ctrl, input int wait_n);
      logic        is_ld, is_st;
      logic [31:0] result, rd;
      is_ld = ctrl[5];
      is_st = ctrl[6];
      @(negedge clk);
      in_pc = pc; in_ir = ir; in_alu = alu; in_op2 = op2; in_ctrl = ctrl; m_ready = 1'b0;
      #1;
      if (!(is_ld || is_st)) begin
         chk("pass_pc", o_pc, pc);
         chk("pass_alu", o_alu, alu);
         chk("pass_ir", o_ir, ir);
         chk("pass_ctrl", 32'(o_ctrl), 32'(ctrl));
         chk("pass_stall", 32'(stall), 0);
         chk("pass_req", 32'(m_req), 0);
         chk("pass_ld", ld_res, 0);
         return;
      end
      chk("idle_stall", 32'(stall), 1);
      chk("idle_bub_ir", o_ir, NOP);
      chk("idle_bub_ctrl", 32'(o_ctrl), 0);
      chk("idle_pc", o_pc, pc);
      chk("idle_req", 32'(m_req), 0);
      chk("idle_ld", ld_res, 0);
      result = 32'd0;
      if (alu[1:0] != 2'b00) begin
         err_exp = 1'b1;
      end else begin
         for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            rd = mem_model.exists(alu) ? mem_model[alu] : $urandom;
            m_rdata = rd;
            m_ready = (k == wait_n);
            #1;
            chk("req_req", 32'(m_req), 1);
            chk("req_we", 32'(m_we), 32'(is_st));
            chk("req_addr", m_addr, alu);
            chk("req_wdata", m_wdata, op2);
            chk("req_stall", 32'(stall), 1);
            chk("req_bub_ir", o_ir, NOP);
            chk("req_bub_ctrl", 32'(o_ctrl), 0);
            chk("req_pc", o_pc, pc);
            if (k == wait_n) begin
               if (is_st) mem_model[alu] = op2;
               else       result = rd;
               break;
            end
            if (k == TO) err_exp = 1'b1;
         end
      end
      @(negedge clk);
      m_ready = 1'b0;
      m_rdata = $urandom;
      #1;
      chk("done_stall", 32'(stall), 0);
      chk("done_req", 32'(m_req), 0);
      chk("done_pc", o_pc, pc);
      chk("done_ir", o_ir, ir);
      chk("done_alu", o_alu, alu);
      chk("done_ctrl", 32'(o_ctrl), 32'(ctrl));
      chk("done_ld", ld_res, result);
      chk("done_err", 32'(m_err), 32'(err_exp));
   endtask

   initial begin
      logic [21:0] c;
      int          kind;
      logic [31:0] a;
      // reset state
      #2;
      chk("rst_req", 32'(m_req), 0);
      chk("rst_we", 32'(m_we), 0);
      chk("rst_err", 32'(m_err), 0);
      chk("rst_stall", 32'(stall), 0);
      @(negedge clk); rst_n = 1'b1;

      // ALU op pass-through
      do_op(32'h40, 32'h0, 32'h1234, 32'h5, 22'h000081, 1);
      // load, immediate ready
      mem_model[32'h100] = 32'hDEAD_BEEF;
      do_op(32'h44, 32'h1111_0001, 32'h100, 32'h0, 22'h000020, 1);
      // store, 3-cycle wait
      do_op(32'h48, 32'h2222_0002, 32'h200, 32'hCAFE_F00D, 22'h000040, 3);
      // read back the stored word
      do_op(32'h4C, 32'h3333_0003, 32'h200, 32'h0, 22'h000020, 2);
      // timeout
      do_op(32'h50, 32'h4444_0004, 32'h300, 32'h0, 22'h000020, TO + 1);
      // misaligned load (error stays sticky)
      do_op(32'h54, 32'h5555_0005, 32'h102, 32'h0, 22'h000020, 1);
      // ld+st both set behaves as a store
      do_op(32'h58, 32'h6666_0006, 32'h104, 32'h77, 22'h000060, 1);

      // random mix
      for (int i = 0; i < 40; i++) begin
         kind = int'($urandom_range(0, 4));
         c = 22'($urandom) & ~22'h60;
         a = {22'd0, 8'($urandom_range(0, 15)), 2'b00} + 32'h400;
         case (kind)
            0: ;
            1: c[5] = 1'b1;
            2: c[6] = 1'b1;
            3: begin c[5] = 1'b1; c[6] = 1'b1; end
            default: begin c[5] = 1'b1; a[1:0] = 2'($urandom_range(1, 3)); end
         endcase
         do_op($urandom, $urandom, a, $urandom, c, int'($urandom_range(1, TO + 1)));
      end

      // reset during the second REQ cycle
      @(negedge clk);
      in_pc = 32'h90; in_ir = 32'h7777_0007; in_alu = 32'h500; in_ctrl = 22'h000020;
      m_ready = 1'b0;
      @(negedge clk);          // first REQ cycle
      #1;
      chk("rreq_req1", 32'(m_req), 1);
      @(negedge clk);          // second REQ cycle
      #1;
      rst_n = 1'b0;
      #1;
      chk("rreq_req_drop", 32'(m_req), 0);
      chk("rreq_we_drop", 32'(m_we), 0);
      chk("rreq_err", 32'(m_err), 0);
      chk("rreq_idle_stall", 32'(stall), 1);
      chk("rreq_idle_ir", o_ir, NOP);
      err_exp = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      in_ctrl = 22'h0; in_ir = 32'h8888_0008;
      #1;
      chk("rreq_after_ir", o_ir, 32'h8888_0008);
      chk("rreq_after_stall", 32'(stall), 0);
      @(negedge clk);
      #1;
      chk("rreq_nodone_ld", ld_res, 0);
      chk("rreq_nodone_ir", o_ir, 32'h8888_0008);
      // stage works normally after the abandoned request
      do_op(32'hA0, 32'h9999_0009, 32'h600, 32'h0, 22'h000020, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
